// File: rtl/rng_gen_pool_if.sv
// ----------------------------------------------------------------------------
// rng_gen_pool_if : output-word handshake bundle for rng_gen_pool
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface rng_gen_pool_if #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
);
  logic                           out_valid;
  logic                           out_ready;
  logic [WIDTH-1:0]               output_signal;
  logic [$clog2(DEPTH+1)-1:0]     fill_level;

  modport master (output out_valid, output output_signal, output fill_level, input out_ready);
  modport slave  (input out_valid, input output_signal, input fill_level, output out_ready);
endinterface

`default_nettype wire

// File: rtl/rng_gen_pool.sv
// ----------------------------------------------------------------------------
// rng_gen_pool : multi-lane Galois-LFSR word generator feeding a show-ahead FIFO
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rng_gen_pool #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        enable,
  input  wire logic        seed_valid,
  input  wire logic [31:0] seed,
  output logic             health_fail,
  rng_gen_pool_if.master   out_if
);

  localparam int LANES = WIDTH / 32;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [31:0] c_poly       = 32'h0040_0007;
  localparam logic [31:0] c_stride     = 32'h0101_0101;
  localparam logic [31:0] c_reset_base = 32'hACE1_0001;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             health_fail_q, health_fail_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             out_valid;
  logic             full;
  logic             pop;
  logic             push;
  logic [WIDTH-1:0] word;
  logic [LANES-1:0] lane_zero;
  logic [LANES-1:0] seed_zero;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign out_valid = (count_q != '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign pop       = out_valid & out_if.out_ready;
  // A pop frees the slot on the same edge, so a full FIFO can still accept a push.
  assign push      = enable & ~seed_valid & ~health_fail_q & (~full | pop);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam logic [31:0] c_offset = 32'(i) * c_stride;

    logic [31:0] lane_q, lane_d;
    logic [31:0] seeded;

    assign seeded = seed ^ c_offset;

    always_comb begin
      lane_d = lane_q;
      if (seed_valid) begin
        lane_d = seeded;
      end else if (push) begin
        lane_d = {lane_q[30:0], 1'b0} ^ (lane_q[31] ? c_poly : 32'h0);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lane_q <= c_reset_base ^ c_offset;
      end else begin
        lane_q <= lane_d;
      end
    end

    assign word[i*32 +: 32] = lane_q;
    assign lane_zero[i]     = (lane_q == 32'h0);
    assign seed_zero[i]     = (seeded == 32'h0);
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    health_fail_d = health_fail_q | (|lane_zero);
    if (seed_valid) begin
      // Reseed flushes the FIFO and re-evaluates health from the new lane values.
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      health_fail_d = |seed_zero;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      health_fail_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      health_fail_q <= health_fail_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= word;
    end
  end

  assign out_if.out_valid     = out_valid;
  assign out_if.fill_level    = count_q;
  assign out_if.output_signal = out_valid ? mem_q[rd_ptr_q] : '0;
  assign health_fail          = health_fail_q;

endmodule

`default_nettype wire

// File: tb/tb_rng_gen_pool.sv
// ----------------------------------------------------------------------------
// tb_rng_gen_pool : directed checks plus randomized scoreboard run for rng_gen_pool
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_rng_gen_pool;

  localparam int WIDTH = 128;
  localparam int DEPTH = 4;
  localparam int LANES = WIDTH / 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        seed_valid = 1'b0;
  logic [31:0] seed = 32'h0;
  logic        health_fail;

  int n_vec = 0;
  int n_err = 0;

  rng_gen_pool_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  rng_gen_pool #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .seed_valid (seed_valid),
    .seed       (seed),
    .health_fail(health_fail),
    .out_if     (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: lane states, health flag and the queue of words the DUT should emit.
  logic [31:0]      m_lane [LANES];
  logic             m_health;
  logic [WIDTH-1:0] exp_q [$];

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s << 1) ^ (s[31] ? 32'h0040_0007 : 32'h0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) m_lane[i] = 32'hACE1_0001 ^ (32'(i) * 32'h0101_0101);
      m_health = 1'b0;
      exp_q.delete();
    end else if (seed_valid) begin
      m_health = 1'b0;
      for (int i = 0; i < LANES; i++) begin
        m_lane[i] = seed ^ (32'(i) * 32'h0101_0101);
        if (m_lane[i] == 32'h0) m_health = 1'b1;
      end
      exp_q.delete();
    end else if (enable && !m_health && exp_q.size() < DEPTH) begin
      // Monitor has already removed this cycle's popped word, so size < DEPTH covers push-with-pop.
      logic [WIDTH-1:0] w;
      for (int i = 0; i < LANES; i++) begin
        w[i*32 +: 32] = m_lane[i];
        m_lane[i]     = lfsr_next(m_lane[i]);
      end
      exp_q.push_back(w);
    end
  end

  always @(negedge clk) begin
    chk("fill_level", WIDTH'(bus.fill_level), WIDTH'(exp_q.size()));
    chk("out_valid", WIDTH'(bus.out_valid), WIDTH'(exp_q.size() > 0));
    chk("health_fail", WIDTH'(health_fail), WIDTH'(m_health));
    if (bus.fill_level > DEPTH) chk("fill_bound", WIDTH'(bus.fill_level), WIDTH'(DEPTH));
    if (bus.out_valid && bus.out_ready && !seed_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", bus.output_signal, '0);
      end else begin
        chk("pop_word", bus.output_signal, exp_q.pop_front());
      end
    end else if (exp_q.size() == 0) begin
      chk("empty_head", bus.output_signal, '0);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    step(3);
    chk("rst_valid", WIDTH'(bus.out_valid), '0);
    chk("rst_fill", WIDTH'(bus.fill_level), '0);
    chk("rst_word", bus.output_signal, '0);
    chk("rst_health", WIDTH'(health_fail), '0);

    rst_n  = 1'b1;
    enable = 1'b1;
    step(1);
    chk("first_valid", WIDTH'(bus.out_valid), WIDTH'(1));
    chk("first_word", bus.output_signal, 128'hAFE20302_AEE30203_ADE00100_ACE10001);
    step(3);
    chk("fill_full", WIDTH'(bus.fill_level), WIDTH'(4));
    step(1);
    chk("fill_hold", WIDTH'(bus.fill_level), WIDTH'(4));
    chk("head_hold", bus.output_signal, 128'hAFE20302_AEE30203_ADE00100_ACE10001);

    bus.out_ready = 1'b1;
    step(1);
    bus.out_ready = 1'b0;
    chk("second_word_lo", WIDTH'(bus.output_signal[31:0]), WIDTH'(32'h5982_0005));
    chk("fill_push_pop", WIDTH'(bus.fill_level), WIDTH'(4));

    seed_valid = 1'b1;
    seed       = 32'h0;
    step(1);
    seed_valid = 1'b0;
    chk("zseed_fill", WIDTH'(bus.fill_level), '0);
    chk("zseed_valid", WIDTH'(bus.out_valid), '0);
    chk("zseed_health", WIDTH'(health_fail), WIDTH'(1));
    step(3);
    chk("blocked_fill", WIDTH'(bus.fill_level), '0);

    seed_valid = 1'b1;
    seed       = 32'h1;
    step(1);
    seed_valid = 1'b0;
    chk("reseed_health", WIDTH'(health_fail), '0);
    step(1);
    chk("reseed_word", bus.output_signal, 128'h03030302_02020203_01010100_00000001);
    step(2);
    chk("pre_rst_fill", WIDTH'(bus.fill_level), WIDTH'(3));

    enable = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", WIDTH'(bus.out_valid), '0);
    chk("async_fill", WIDTH'(bus.fill_level), '0);
    chk("async_word", bus.output_signal, '0);
    step(2);
    rst_n = 1'b1;

    for (int c = 0; c < 10000; c++) begin
      enable        = ($urandom_range(0, 99) < 75);
      bus.out_ready = ($urandom_range(0, 99) < 50);
      seed_valid    = ($urandom_range(0, 999) < 3);
      if ($urandom_range(0, 3) == 0) seed = 32'($urandom_range(0, 3)) * 32'h0101_0101;
      else                           seed = $urandom;
      step(1);
    end
    seed_valid = 1'b0;
    enable     = 1'b0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rng_gen_pool.md
RNG_GEN_POOL -- requirements
Module: rng_gen_pool

Interface
REQ-001 Parameter WIDTH, default 128: output word width; SHALL be a multiple of 32, minimum 32; LANES = WIDTH/32.
REQ-002 Parameter DEPTH, default 4: output FIFO depth in words; SHALL be at least 2.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 enable  input  1  generation enable; when low, no new words are produced.
REQ-006 seed_valid  input  1  one-cycle reseed strobe.
REQ-007 seed  input  32  reseed value, sampled when seed_valid=1.
REQ-008 out_ready  input  1  consumer accepts the head word.
REQ-009 out_valid  output  1  FIFO non-empty.
REQ-010 output_signal  output  WIDTH  FIFO head word; all-zero when empty.
REQ-011 fill_level  output  $clog2(DEPTH+1)  current FIFO occupancy.
REQ-012 health_fail  output  1  sticky: at least one lane state is zero.

Function
REQ-013 Each lane i (0..LANES-1) SHALL hold a 32-bit Galois LFSR state.
- Step: next = {s[30:0],1'b0} ^ (s[31] ? 32'h0040_0007 : 0).
REQ-014 Lane reset state SHALL be 32'hACE1_0001 ^ (i * 32'h0101_0101).
REQ-015 The generated word SHALL be {lane[LANES-1], ..., lane[0]}, taken from the pre-step states.
REQ-016 push SHALL occur when enable=1, seed_valid=0, health_fail=0, and (fill_level<DEPTH or pop occurs this cycle).
REQ-017 All lanes SHALL step exactly once per push and SHALL hold otherwise.
REQ-018 pop SHALL occur when out_valid=1 and out_ready=1.
REQ-019 The FIFO SHALL be show-ahead: output_signal equals the oldest entry; the first push is visible one cycle after the push edge.
REQ-020 On simultaneous push and pop:
- occupancy unchanged;
- when full, the popped slot is reused and no overflow occurs.
REQ-021 Words SHALL exit the FIFO in push order; read/write pointers wrap modulo DEPTH.
REQ-022 On seed_valid=1:
- lane i loads seed ^ (i * 32'h0101_0101);
- the FIFO is flushed (fill_level=0, out_valid=0 next cycle);
- any same-cycle pop or push is discarded.
REQ-023 health_fail SHALL be set the cycle after any lane state becomes zero (reachable only through a reseed).
REQ-024 health_fail SHALL be cleared only by reset or by a reseed that makes every lane nonzero.
REQ-025 While health_fail=1, pushes SHALL be blocked; pops of already-buffered words continue.
REQ-026 fill_level SHALL never exceed DEPTH; a pop when empty SHALL be ignored.

Reset
REQ-027 rst_n=0 SHALL immediately set:
- lanes to their REQ-014 values;
- FIFO pointers to 0, fill_level=0;
- out_valid=0, output_signal=0, health_fail=0.
REQ-028 Reset mid-operation SHALL discard all buffered words.
REQ-029 The first push is permitted on the first rising edge after rst_n deasserts.

Verification (WIDTH=128, DEPTH=4)
REQ-030 Reset release, enable=1, out_ready=0:
- after edge 1: out_valid=1, output_signal=128'hAFE20302_AEE30203_ADE00100_ACE10001;
- after edge 4: fill_level=4, and lanes hold from then on.
REQ-031 Continue REQ-030 with out_ready=1 for one cycle:
- the second word appears, with bits [31:0]=32'h5982_0005;
- fill_level remains 4 because a simultaneous push and pop occur.
REQ-032 seed_valid=1, seed=32'h0000_0000:
- next cycle: fill_level=0, out_valid=0, health_fail=1;
- no pushes occur while enable=1.
REQ-033 Then seed_valid=1, seed=32'h0000_0001:
- health_fail=0;
- the next word = 128'h03030302_02020203_01010100_00000001.
REQ-034 Assert rst_n=0 asynchronously mid-cycle with fill_level=3: out_valid, fill_level and output_signal read 0 before the next clock edge.
REQ-035 Random enable/out_ready for 10k cycles against a reference model:
- zero word loss or duplication;
- fill_level stays within 0..4.
